// File: rtl/text_vram_arbiter_if.sv
// rtl/text_vram_arbiter_if.sv - display, host and VRAM signals of the text VRAM arbiter
interface text_vram_arbiter_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 16
);
    logic                  in_disp_req;
    logic [ADDR_WIDTH-1:0] in_disp_address;
    logic [DATA_WIDTH-1:0] out_disp_data;
    logic                  out_disp_valid;
    logic                  in_host_wr_valid;
    logic [ADDR_WIDTH-1:0] in_host_wr_address;
    logic [DATA_WIDTH-1:0] in_host_wr_data;
    logic                  out_host_wr_ready;
    logic                  in_host_rd_req;
    logic [ADDR_WIDTH-1:0] in_host_rd_address;
    logic [DATA_WIDTH-1:0] out_host_rd_data;
    logic                  out_host_rd_ack;
    logic [ADDR_WIDTH-1:0] out_vmem_address;
    logic [DATA_WIDTH-1:0] out_vmem_wdata;
    logic                  out_vmem_we;
    logic [DATA_WIDTH-1:0] in_vmem_rdata;
    logic                  out_busy;

    modport slave (
        input  in_disp_req, in_disp_address,
        output out_disp_data, out_disp_valid,
        input  in_host_wr_valid, in_host_wr_address, in_host_wr_data,
        output out_host_wr_ready,
        input  in_host_rd_req, in_host_rd_address,
        output out_host_rd_data, out_host_rd_ack,
        output out_vmem_address, out_vmem_wdata, out_vmem_we,
        input  in_vmem_rdata,
        output out_busy
    );

    modport master (
        output in_disp_req, in_disp_address,
        input  out_disp_data, out_disp_valid,
        output in_host_wr_valid, in_host_wr_address, in_host_wr_data,
        input  out_host_wr_ready,
        output in_host_rd_req, in_host_rd_address,
        input  out_host_rd_data, out_host_rd_ack,
        input  out_vmem_address, out_vmem_wdata, out_vmem_we,
        output in_vmem_rdata,
        input  out_busy
    );
endinterface

// File: rtl/text_vram_arbiter.sv
// rtl/text_vram_arbiter.sv - single-port text VRAM shared by display fetch and host port
module text_vram_arbiter #(
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 16,
    parameter int WFIFO_DEPTH = 4
) (
    input logic                 in_clock,
    input logic                 in_reset_n,
    text_vram_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(WFIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_REQ,
        RD_ISSUED,
        RD_DATA,
        RD_ACK
    } rd_state_e;

    logic [ADDR_WIDTH-1:0] fifo_addr_q [WFIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [WFIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  wr_ready_q, wr_ready_d;
    rd_state_e             rd_state_q, rd_state_d;
    logic [ADDR_WIDTH-1:0] vmem_addr_q, vmem_addr_d;
    logic [DATA_WIDTH-1:0] vmem_wdata_q, vmem_wdata_d;
    logic                  vmem_we_q, vmem_we_d;
    logic [1:0]            disp_pipe_q, disp_pipe_d;
    logic                  disp_valid_q, disp_valid_d;
    logic [DATA_WIDTH-1:0] disp_data_q, disp_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_ack_q, rd_ack_d;
    logic                  busy_q, busy_d;

    logic fifo_empty, full_d, push, pop;
    logic disp_gnt, wr_gnt, rd_gnt;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign push       = bus.in_host_wr_valid && wr_ready_q;

    // Display always wins; a read waits for an empty FIFO so it sees every accepted write.
    assign disp_gnt = bus.in_disp_req;
    assign wr_gnt   = !disp_gnt && !fifo_empty;
    assign rd_gnt   = !disp_gnt && fifo_empty && (rd_state_q == RD_REQ);
    assign pop      = wr_gnt;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{IDX_W{1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{IDX_W{1'b0}}, pop};
        full_d     = (wr_ptr_d[PTR_W-1] != rd_ptr_d[PTR_W-1]) &&
                     (wr_ptr_d[IDX_W-1:0] == rd_ptr_d[IDX_W-1:0]);
        wr_ready_d = !full_d;
    end

    always_comb begin
        vmem_addr_d  = vmem_addr_q;
        vmem_wdata_d = vmem_wdata_q;
        vmem_we_d    = 1'b0;
        if (disp_gnt) begin
            vmem_addr_d = bus.in_disp_address;
        end else if (wr_gnt) begin
            vmem_addr_d  = fifo_addr_q[rd_ptr_q[IDX_W-1:0]];
            vmem_wdata_d = fifo_data_q[rd_ptr_q[IDX_W-1:0]];
            vmem_we_d    = 1'b1;
        end else if (rd_gnt) begin
            vmem_addr_d = bus.in_host_rd_address;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_data_d  = rd_data_q;
        rd_ack_d   = 1'b0;
        case (rd_state_q)
            RD_IDLE:   if (bus.in_host_rd_req) rd_state_d = RD_REQ;
            RD_REQ:    if (rd_gnt) rd_state_d = RD_ISSUED;
            RD_ISSUED: rd_state_d = RD_DATA;
            RD_DATA: begin
                rd_state_d = RD_ACK;
                rd_data_d  = bus.in_vmem_rdata;
                rd_ack_d   = 1'b1;
            end
            RD_ACK:    rd_state_d = RD_IDLE;
            default:   rd_state_d = RD_IDLE;
        endcase
    end

    // The RAM answers one edge after the address register, so data is captured two edges after grant.
    always_comb begin
        disp_pipe_d  = {disp_pipe_q[0], disp_gnt};
        disp_valid_d = disp_pipe_q[1];
        disp_data_d  = disp_pipe_q[1] ? bus.in_vmem_rdata : disp_data_q;
        busy_d       = (wr_ptr_d != rd_ptr_d) || (rd_state_d != RD_IDLE);
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            wr_ready_q   <= 1'b1;
            rd_state_q   <= RD_IDLE;
            vmem_addr_q  <= '0;
            vmem_wdata_q <= '0;
            vmem_we_q    <= 1'b0;
            disp_pipe_q  <= '0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
            rd_data_q    <= '0;
            rd_ack_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ready_q   <= wr_ready_d;
            rd_state_q   <= rd_state_d;
            vmem_addr_q  <= vmem_addr_d;
            vmem_wdata_q <= vmem_wdata_d;
            vmem_we_q    <= vmem_we_d;
            disp_pipe_q  <= disp_pipe_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
            rd_data_q    <= rd_data_d;
            rd_ack_q     <= rd_ack_d;
            busy_q       <= busy_d;
        end
    end

    always_ff @(posedge in_clock) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q[IDX_W-1:0]] <= bus.in_host_wr_address;
            fifo_data_q[wr_ptr_q[IDX_W-1:0]] <= bus.in_host_wr_data;
        end
    end

    assign bus.out_disp_data     = disp_data_q;
    assign bus.out_disp_valid    = disp_valid_q;
    assign bus.out_host_wr_ready = wr_ready_q;
    assign bus.out_host_rd_data  = rd_data_q;
    assign bus.out_host_rd_ack   = rd_ack_q;
    assign bus.out_vmem_address  = vmem_addr_q;
    assign bus.out_vmem_wdata    = vmem_wdata_q;
    assign bus.out_vmem_we       = vmem_we_q;
    assign bus.out_busy          = busy_q;
endmodule
